// File: rtl/ser2par8.sv
// Serial frame receiver: start bit, W data bits LSB first, stop bit.
// A good frame loads dout with a one-clock PL pulse; a bad stop bit raises ferr and holds off until idle.
module ser2par8 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ben,
    input  logic         sin,
    output logic [W-1:0] dout,
    output logic         PL,
    output logic         ferr
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2,
        BRK  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            dout  <= '0;
            PL    <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            // Pulses last one clock whether or not a strobe follows.
            PL   <= 1'b0;
            ferr <= 1'b0;
            if (ben) begin
                case (state)
                    IDLE: begin
                        if (!sin) begin
                            state <= DATA;
                            cnt   <= '0;
                        end
                    end
                    DATA: begin
                        shreg <= {sin, shreg[W-1:1]};
                        if (cnt == CW'(W - 1)) begin
                            state <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (sin) begin
                            dout  <= shreg;
                            PL    <= 1'b1;
                            state <= IDLE;
                        end else begin
                            ferr  <= 1'b1;
                            state <= BRK;
                        end
                    end
                    BRK: begin
                        if (sin) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ser2par8.sv
// Directed bench for ser2par8: framing, strobe gating, error recovery, back-to-back frames and reset.
module tb_ser2par8;

    logic       clk;
    logic       rst;
    logic       ben;
    logic       sin;
    logic [7:0] dout;
    logic       PL;
    logic       ferr;

    ser2par8 #(.W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .ben  (ben),
        .sin  (sin),
        .dout (dout),
        .PL   (PL),
        .ferr (ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pl_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int cyc = 0;
    logic [7:0] reg_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) reg_q <= 8'h00;
        else if (PL) reg_q <= dout;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (PL) pl_cnt++;
            if (ferr) fe_cnt++;
            if (PL && ferr) both_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic b, input int gap);
        ben = 1'b1;
        sin = b;
        @(posedge clk);
        #1;
        ben = 1'b0;
        for (int i = 0; i < gap; i++) begin
            sin = ~b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopb, input int gap);
        strobe(1'b0, gap);
        for (int i = 0; i < 8; i++) strobe(d[i], gap);
        strobe(stopb, 0);
    endtask

    task automatic idle(input int n);
        ben = 1'b0;
        sin = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int p0, f0, t1;

    initial begin
        rst = 1'b1;
        ben = 1'b0;
        sin = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_do", 32'(dout), 32'h00);
        chk("rst_pl", 32'(PL), 0);
        chk("rst_ferr", 32'(ferr), 0);
        chk("rst_state", 32'(dut.state), 0);
        rst = 1'b0;
        idle(2);

        // Frame 0xAF, one bit per clock.
        p0 = pl_cnt; f0 = fe_cnt;
        send_frame(8'hAF, 1'b1, 0);
        chk("af_pl", 32'(PL), 1);
        chk("af_do", 32'(dout), 32'hAF);
        idle(1);
        chk("af_pl_drop", 32'(PL), 0);
        chk("af_reg", 32'(reg_q), 32'hAF);
        chk("af_plcnt", 32'(pl_cnt - p0), 1);
        chk("af_fecnt", 32'(fe_cnt - f0), 0);

        // Same frame with one strobe in four; sin inverted on off-strobe cycles.
        idle(2);
        p0 = pl_cnt;
        strobe(1'b0, 3);
        strobe(1'b1, 3);
        strobe(1'b1, 3);
        chk("gap_cnt", 32'(dut.cnt), 2);
        chk("gap_shreg_top", 32'(dut.shreg[7:6]), 32'h3);
        for (int i = 2; i < 8; i++) begin
            logic [7:0] v;
            v = 8'hAF;
            strobe(v[i], 3);
        end
        strobe(1'b1, 0);
        chk("gap_pl", 32'(PL), 1);
        chk("gap_do", 32'(dout), 32'hAF);
        idle(1);
        chk("gap_plcnt", 32'(pl_cnt - p0), 1);

        // Framing error on 0x3C, then a held-low line.
        idle(2);
        p0 = pl_cnt; f0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 0);
        chk("err_ferr", 32'(ferr), 1);
        chk("err_pl", 32'(PL), 0);
        chk("err_do", 32'(dout), 32'hAF);
        idle(1);
        chk("err_ferr_drop", 32'(ferr), 0);
        strobe(1'b0, 0);
        strobe(1'b0, 0);
        strobe(1'b0, 0);
        chk("brk_hold", 32'(dut.state), 3);
        strobe(1'b1, 0);
        chk("brk_exit", 32'(dut.state), 0);
        chk("err_fecnt", 32'(fe_cnt - f0), 1);
        chk("err_plcnt", 32'(pl_cnt - p0), 0);
        chk("err_do_kept", 32'(dout), 32'hAF);
        idle(1);
        send_frame(8'h55, 1'b1, 0);
        chk("r55_pl", 32'(PL), 1);
        chk("r55_do", 32'(dout), 32'h55);

        // Back-to-back 0x01 then 0xFE with no idle bits.
        idle(2);
        p0 = pl_cnt;
        send_frame(8'h01, 1'b1, 0);
        chk("b2b1_pl", 32'(PL), 1);
        chk("b2b1_do", 32'(dout), 32'h01);
        t1 = cyc;
        send_frame(8'hFE, 1'b1, 0);
        chk("b2b2_pl", 32'(PL), 1);
        chk("b2b2_do", 32'(dout), 32'hFE);
        chk("b2b_spacing", 32'(cyc - t1), 10);
        idle(1);
        chk("b2b_plcnt", 32'(pl_cnt - p0), 2);

        // Reset after 4 data bits of 0xF0; the trailing ones must be ignored.
        idle(2);
        p0 = pl_cnt;
        strobe(1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(1'b0, 0);
        rst = 1'b1;
        ben = 1'b1;
        sin = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_do", 32'(dout), 0);
        chk("mrst_pl", 32'(PL), 0);
        chk("mrst_ferr", 32'(ferr), 0);
        chk("mrst_state", 32'(dut.state), 0);
        for (int i = 0; i < 4; i++) strobe(1'b1, 0);
        strobe(1'b1, 0);
        chk("mrst_ignored_state", 32'(dut.state), 0);
        chk("mrst_ignored_pl", 32'(pl_cnt - p0), 0);
        send_frame(8'hA5, 1'b1, 0);
        chk("a5_pl", 32'(PL), 1);
        chk("a5_do", 32'(dout), 32'hA5);

        // Idle line with strobes every clock.
        idle(1);
        p0 = pl_cnt; f0 = fe_cnt;
        for (int i = 0; i < 20; i++) strobe(1'b1, 0);
        chk("idle_plcnt", 32'(pl_cnt - p0), 0);
        chk("idle_fecnt", 32'(fe_cnt - f0), 0);
        chk("idle_do", 32'(dout), 32'hA5);
        chk("pl_ferr_overlap", 32'(both_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ser2par8.md
# ser2par8

Serial-to-parallel frame receiver that sits directly upstream of the 8-bit parallel-load register. It samples a one-wire serial line on a bit-enable strobe and recognises start/data/stop framing. It assembles each data word LSB first and, on a valid stop bit, presents the word on `do` with a one-clock `PL` pulse. `do` and `PL` connect straight to the register's `di` and `PL` inputs. Malformed frames are reported on `ferr`, and the line is held off until it returns idle.

## Interface
- `W`, default 8: number of data bits per frame; `do` width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high; one clock, reset is synchronous and active-high.
- `ben`  in  1  bit-enable strobe; `sin` is sampled only on edges where `ben`=1.
- `sin`  in  1  serial line, idle high, start bit 0, W data bits LSB first, stop bit 1.
- `do`   out W  last correctly framed word; feeds register `di`.
- `PL`   out 1  one-clock pulse, high in the cycle `do` holds a newly received word; feeds register `PL`.
- `ferr` out 1  one-clock pulse, framing error (stop bit sampled 0).

## Operation
- Reset values: `do`=0, `PL`=0, `ferr`=0, state=IDLE, bit counter=0, shift register=0.
- The block has four states. None advances without `ben`=1.
  - IDLE: `ben`&`sin`=0 → DATA, counter cleared. `ben`&`sin`=1 → stay.
  - DATA: each `ben` shifts in `sin` (shreg <= {sin, shreg[W-1:1]}) and increments the counter. The strobe that captures bit W-1 → STOP.
  - STOP, `ben`&`sin`=1: `do`<=shreg, `PL`<=1, → IDLE.
  - STOP, `ben`&`sin`=0: `ferr`<=1, `do` unchanged, `PL` stays 0, → BRK.
  - BRK: `ben`&`sin`=1 → IDLE. `ben`&`sin`=0 → stay. No output activity.
- `PL` and `ferr` are registered and high for exactly one clock. They are never high together.
- `PL` and `ferr` deassert on the following edge regardless of `ben`.
- The counter is wide enough for W-1 and is cleared on entry to DATA. The counter has no wrap-around beyond W-1.
- `do` holds its value between frames. A framing error never corrupts `do`.
- `rst` has priority over everything. Mid-frame reset discards partial data and returns to IDLE with all outputs 0 on the next edge.
- `ben`=0 cycles inside a frame freeze state, counter and shift register.

## Timing
- A frame consumes W+2 `ben` strobes: 1 start, W data, 1 stop.
- `PL` and the new `do` appear on the clock edge that samples the stop bit, and are visible in the following cycle.
- The downstream register captures `do` on the next rising edge, 1 clock after the stop sample.
- `ben` may be held high continuously, giving one bit per clock with no gap.
- A new start bit may be sampled on the very next `ben` after the stop bit. Back-to-back frames need zero idle bits.
- A `ben` in the cycle where `PL`=1 is processed normally by IDLE.

## Test plan
- Reset, then `ben`=1 every clock, `sin` = 0,1,1,1,1,0,1,0,1,1.
  - → `do`=8'hAF with `PL`=1 for one clock after the 10th sample.
  - → `ferr`=0 throughout.
  - → register downstream holds 8'hAF one clock later.
- Same frame with `ben` high one clock in four, `sin` changed only between strobes.
  - → identical result; `PL` appears after the 10th strobe.
  - → state unchanged on all `ben`=0 cycles.
- Frame with data 8'h3C and stop bit 0, then `sin`=0 for 3 strobes, then 1.
  - → `ferr` one-clock pulse, `PL` never high, `do` keeps its previous value.
  - → block returns to IDLE only after the `sin`=1 strobe.
  - → a following 8'h55 frame is received correctly.
- Two back-to-back frames 8'h01 then 8'hFE, no idle bits, `ben` every clock.
  - → two `PL` pulses exactly 10 clocks apart.
  - → `do`=8'h01, then 8'hFE.
- Assert `rst` for one clock after 4 data bits of a frame.
  - → next cycle all outputs 0, state IDLE.
  - → remaining bits of the aborted frame are ignored until a new 0 start bit.
  - → a complete 8'hA5 frame then yields `do`=8'hA5.
- Idle line `sin`=1 with `ben`=1 for 20 clocks.
  - → no `PL`, no `ferr`, `do` unchanged.
